// File: rtl/vx_mem_flow_ctrl.sv
// ============================================================================
//  Module   : vx_mem_flow_ctrl
//  Purpose  : Memory request flow control. Registers upstream requests in a
//             one-entry slice before they reach memory, limits the number of
//             outstanding reads, and passes memory responses straight back
//             upstream.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset          : clock, synchronous active-high reset
//    in_req_*            : upstream request (valid/ready handshake)
//    mem_req_*           : downstream request to memory (valid/ready)
//    mem_rsp_*           : response from memory (valid/ready)
//    in_rsp_*            : response to upstream (combinational pass-through)
//    pending             : number of reads accepted and not yet answered
//    busy                : reads outstanding or a request held in the slice
//    rsp_err             : sticky; set by a response that arrives while
//                          pending == 0, cleared only by reset
//    perf_reads/_writes/_stall_cycles (64 bit) : present only when the
//                          macro VX_MEM_FLOW_PERF_EN is defined
// ============================================================================
`default_nettype none

module vx_mem_flow_ctrl #(
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 26,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16
) (
  input  logic                             clk,
  input  logic                             reset,

  // upstream request
  input  logic                             in_req_valid,
  input  logic                             in_req_rw,
  input  logic [DATA_WIDTH/8-1:0]          in_req_byteen,
  input  logic [ADDR_WIDTH-1:0]            in_req_addr,
  input  logic [DATA_WIDTH-1:0]            in_req_data,
  input  logic [TAG_WIDTH-1:0]             in_req_tag,
  output logic                             in_req_ready,

  // downstream request
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [DATA_WIDTH/8-1:0]          mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [TAG_WIDTH-1:0]             mem_req_tag,
  input  logic                             mem_req_ready,

  // response from memory
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [TAG_WIDTH-1:0]             mem_rsp_tag,
  output logic                             mem_rsp_ready,

  // response to upstream
  output logic                             in_rsp_valid,
  output logic [DATA_WIDTH-1:0]            in_rsp_data,
  output logic [TAG_WIDTH-1:0]             in_rsp_tag,
  input  logic                             in_rsp_ready,

  // status
  output logic [$clog2(MAX_PENDING+1)-1:0] pending,
  output logic                             busy,
`ifdef VX_MEM_FLOW_PERF_EN
  output logic [63:0]                      perf_reads,
  output logic [63:0]                      perf_writes,
  output logic [63:0]                      perf_stall_cycles,
`endif
  output logic                             rsp_err
);

  localparam int                    c_BE_W      = DATA_WIDTH / 8;
  localparam int                    c_PEND_W    = $clog2(MAX_PENDING + 1);
  localparam logic [c_PEND_W-1:0]   c_MAX_PEND  = c_PEND_W'(MAX_PENDING);
  localparam logic [c_PEND_W-1:0]   c_PEND_ONE  = c_PEND_W'(1);
  localparam logic [c_PEND_W-1:0]   c_PEND_ZERO = '0;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic                  r_req_valid;
  logic                  r_req_rw;
  logic [c_BE_W-1:0]     r_req_byteen;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_req_data;
  logic [TAG_WIDTH-1:0]  r_req_tag;
  logic [c_PEND_W-1:0]   r_pending;
  logic                  r_rsp_err;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic w_slice_free;   // slice can take a new entry this cycle
  logic w_rd_room;      // another read may be issued
  logic w_req_fire;     // upstream request accepted
  logic w_rd_fire;      // accepted request is a read
  logic w_rsp_fire;     // response handed upstream
  logic w_rsp_under;    // response with nothing outstanding
  logic w_rsp_dec;      // response that actually retires a read

  // The slice is free when empty, or when its current entry leaves this cycle;
  // this second term is what gives full throughput back-to-back.
  assign w_slice_free = !r_req_valid || mem_req_ready;

  // Only reads count against the outstanding limit; writes are never throttled.
  assign w_rd_room    = in_req_rw || (r_pending < c_MAX_PEND);

  assign in_req_ready = w_slice_free && w_rd_room;
  assign w_req_fire   = in_req_valid && in_req_ready;
  assign w_rd_fire    = w_req_fire && !in_req_rw;

  assign w_rsp_fire   = mem_rsp_valid && in_rsp_ready;
  assign w_rsp_under  = w_rsp_fire && (r_pending == c_PEND_ZERO);
  assign w_rsp_dec    = w_rsp_fire && !w_rsp_under;

  // --------------------------------------------------------------------------
  // Request slice: valid carries reset, payload is pure datapath and only
  // loads on an accepted request, so it stays frozen while stalled.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_valid <= 1'b0;
    end else if (w_req_fire) begin
      r_req_valid <= 1'b1;
    end else if (mem_req_ready) begin
      r_req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_req_rw     <= in_req_rw;
      r_req_byteen <= in_req_byteen;
      r_req_addr   <= in_req_addr;
      r_req_data   <= in_req_data;
      r_req_tag    <= in_req_tag;
    end
  end

  assign mem_req_valid  = r_req_valid;
  assign mem_req_rw     = r_req_rw;
  assign mem_req_byteen = r_req_byteen;
  assign mem_req_addr   = r_req_addr;
  assign mem_req_data   = r_req_data;
  assign mem_req_tag    = r_req_tag;

  // --------------------------------------------------------------------------
  // Outstanding-read counter. A concurrent accept and retire cancel out.
  // A response while empty never decrements (saturates at 0) and latches
  // the sticky error flag instead.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= c_PEND_ZERO;
    end else begin
      case ({w_rd_fire, w_rsp_dec})
        2'b10:   r_pending <= r_pending + c_PEND_ONE;
        2'b01:   r_pending <= r_pending - c_PEND_ONE;
        default: r_pending <= r_pending;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_err <= 1'b0;
    end else if (w_rsp_under) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign pending = r_pending;
  assign rsp_err = r_rsp_err;
  assign busy    = (r_pending != c_PEND_ZERO) || r_req_valid;

  // --------------------------------------------------------------------------
  // Response path: no storage, straight through in both directions.
  // --------------------------------------------------------------------------
  assign in_rsp_valid  = mem_rsp_valid;
  assign in_rsp_data   = mem_rsp_data;
  assign in_rsp_tag    = mem_rsp_tag;
  assign mem_rsp_ready = in_rsp_ready;

  // --------------------------------------------------------------------------
  // Optional performance counters (free-running, wrap at 2^64)
  // --------------------------------------------------------------------------
`ifdef VX_MEM_FLOW_PERF_EN
  logic [63:0] r_perf_reads;
  logic [63:0] r_perf_writes;
  logic [63:0] r_perf_stall;
  logic        w_wr_fire;
  logic        w_stall;

  assign w_wr_fire = w_req_fire && in_req_rw;
  assign w_stall   = in_req_valid && !in_req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_reads  <= 64'd0;
      r_perf_writes <= 64'd0;
      r_perf_stall  <= 64'd0;
    end else begin
      if (w_rd_fire) begin
        r_perf_reads <= r_perf_reads + 64'd1;
      end
      if (w_wr_fire) begin
        r_perf_writes <= r_perf_writes + 64'd1;
      end
      if (w_stall) begin
        r_perf_stall <= r_perf_stall + 64'd1;
      end
    end
  end

  assign perf_reads        = r_perf_reads;
  assign perf_writes       = r_perf_writes;
  assign perf_stall_cycles = r_perf_stall;
`else
  // Counters not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_vx_mem_flow_ctrl.sv
// ============================================================================
//  Module   : tb_vx_mem_flow_ctrl
//  Purpose  : Directed self-checking bench for vx_mem_flow_ctrl with
//             MAX_PENDING = 4 and a narrow 32-bit data bus. Perf counter
//             checks are included when VX_MEM_FLOW_PERF_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vx_mem_flow_ctrl;

  localparam int DW = 32;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int MP = 4;
  localparam int PW = $clog2(MP + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_req_valid, in_req_rw, in_req_ready;
  logic [DW/8-1:0] in_req_byteen;
  logic [AW-1:0] in_req_addr;
  logic [DW-1:0] in_req_data;
  logic [TW-1:0] in_req_tag;
  logic          mem_req_valid, mem_req_rw, mem_req_ready;
  logic [DW/8-1:0] mem_req_byteen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          in_rsp_valid, in_rsp_ready;
  logic [DW-1:0] in_rsp_data;
  logic [TW-1:0] in_rsp_tag;
  logic [PW-1:0] pending;
  logic          busy, rsp_err;
`ifdef VX_MEM_FLOW_PERF_EN
  logic [63:0]   perf_reads, perf_writes, perf_stall_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vx_mem_flow_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TAG_WIDTH  (TW),
    .MAX_PENDING(MP)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .in_req_valid     (in_req_valid),
    .in_req_rw        (in_req_rw),
    .in_req_byteen    (in_req_byteen),
    .in_req_addr      (in_req_addr),
    .in_req_data      (in_req_data),
    .in_req_tag       (in_req_tag),
    .in_req_ready     (in_req_ready),
    .mem_req_valid    (mem_req_valid),
    .mem_req_rw       (mem_req_rw),
    .mem_req_byteen   (mem_req_byteen),
    .mem_req_addr     (mem_req_addr),
    .mem_req_data     (mem_req_data),
    .mem_req_tag      (mem_req_tag),
    .mem_req_ready    (mem_req_ready),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .mem_rsp_tag      (mem_rsp_tag),
    .mem_rsp_ready    (mem_rsp_ready),
    .in_rsp_valid     (in_rsp_valid),
    .in_rsp_data      (in_rsp_data),
    .in_rsp_tag       (in_rsp_tag),
    .in_rsp_ready     (in_rsp_ready),
    .pending          (pending),
    .busy             (busy),
`ifdef VX_MEM_FLOW_PERF_EN
    .perf_reads       (perf_reads),
    .perf_writes      (perf_writes),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .rsp_err          (rsp_err)
  );

  task automatic chk_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs are driven right after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    in_req_valid  = 1'b1;
    in_req_rw     = rw;
    in_req_addr   = addr;
    in_req_tag    = tag;
    in_req_byteen = 4'hF;
    in_req_data   = {24'hA5A5A5, tag};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    in_req_valid  = 1'b0;
    in_req_rw     = 1'b0;
    in_req_byteen = '0;
    in_req_addr   = '0;
    in_req_data   = '0;
    in_req_tag    = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_tag   = '0;
    in_rsp_ready  = 1'b1;

    // ---------------- reset state ----------------
    do_reset();
    settle();
    chk_vec("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk_vec("rst_pending",   64'(pending),       64'd0);
    chk_vec("rst_busy",      64'(busy),          64'd0);
    chk_vec("rst_err",       64'(rsp_err),       64'd0);
    chk_vec("rst_in_ready",  64'(in_req_ready),  64'd1);

    // ---------------- single read ----------------
    tick();
    drive_req(1'b0, 26'h100, 8'h05);
    settle();
    chk_vec("rd1_ready", 64'(in_req_ready), 64'd1);
    tick();
    in_req_valid = 1'b0;
    settle();
    chk_vec("rd1_mvalid", 64'(mem_req_valid), 64'd1);
    chk_vec("rd1_addr",   64'(mem_req_addr),  64'h100);
    chk_vec("rd1_tag",    64'(mem_req_tag),   64'h5);
    chk_vec("rd1_rw",     64'(mem_req_rw),    64'd0);
    chk_vec("rd1_pend",   64'(pending),       64'd1);
    chk_vec("rd1_busy",   64'(busy),          64'd1);
    tick();
    chk_vec("rd1_drain",  64'(mem_req_valid), 64'd0);
    chk_vec("rd1_busy2",  64'(busy),          64'd1);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = 8'h05;
    mem_rsp_data  = 32'hDEAD_BEEF;
    settle();
    chk_vec("rsp1_valid", 64'(in_rsp_valid),  64'd1);
    chk_vec("rsp1_tag",   64'(in_rsp_tag),    64'h5);
    chk_vec("rsp1_data",  64'(in_rsp_data),   64'hDEADBEEF);
    chk_vec("rsp1_ready", 64'(mem_rsp_ready), 64'd1);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk_vec("rsp1_pend", 64'(pending), 64'd0);
    chk_vec("rsp1_busy", 64'(busy),    64'd0);
    chk_vec("rsp1_err",  64'(rsp_err), 64'd0);

    // ---------------- outstanding limit: 5 reads, limit 4 ----------------
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b0, 26'(32'h200 + i), 8'(i));
      settle();
      chk_vec($sformatf("lim_ready%0d", i), 64'(in_req_ready), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) begin
        tick();
        settle();
        chk_vec($sformatf("lim_fwd_tag%0d", i), 64'(mem_req_tag), 64'(i));
      end
    end
    chk_vec("lim_pend", 64'(pending), 64'd4);
    tick();
    settle();
    chk_vec("lim_stall", 64'(in_req_ready), 64'd0);
    chk_vec("lim_empty", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = 8'h00;
    settle();
    chk_vec("lim_samecyc", 64'(in_req_ready), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk_vec("lim_pend3",  64'(pending),      64'd3);
    chk_vec("lim_accept", 64'(in_req_ready), 64'd1);
    tick();
    in_req_valid = 1'b0;
    settle();
    chk_vec("lim_pend4",  64'(pending),     64'd4);
    chk_vec("lim_fwd5",   64'(mem_req_tag), 64'h4);

    // ---------------- write at pending == MAX ----------------
    drive_req(1'b1, 26'h300, 8'h20);
    settle();
    chk_vec("wr_ready", 64'(in_req_ready), 64'd1);
    tick();
    in_req_valid = 1'b0;
    settle();
    chk_vec("wr_mvalid", 64'(mem_req_valid), 64'd1);
    chk_vec("wr_rw",     64'(mem_req_rw),    64'd1);
    chk_vec("wr_tag",    64'(mem_req_tag),   64'h20);
    chk_vec("wr_pend",   64'(pending),       64'd4);
    // retire the four outstanding reads
    mem_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk_vec("wr_drain_pend", 64'(pending), 64'd0);
    chk_vec("wr_drain_err",  64'(rsp_err), 64'd0);

    // ---------------- backpressure then back-to-back ----------------
    mem_req_ready = 1'b0;
    drive_req(1'b0, 26'h400, 8'h30);
    tick();
    drive_req(1'b0, 26'h401, 8'h31);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_vec($sformatf("bp_ready%0d", i), 64'(in_req_ready), 64'd0);
      chk_vec($sformatf("bp_tag%0d", i),   64'(mem_req_tag),  64'h30);
      chk_vec($sformatf("bp_addr%0d", i),  64'(mem_req_addr), 64'h400);
      tick();
    end
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;   // retire one read per cycle to keep room
    mem_rsp_tag   = 8'h30;
    for (int k = 0; k < 10; k++) begin
      drive_req(1'b0, 26'(32'h401 + k), 8'(8'h31 + k));
      settle();
      chk_vec($sformatf("b2b_ready%0d", k), 64'(in_req_ready), 64'd1);
      tick();
      settle();
      chk_vec($sformatf("b2b_tag%0d", k), 64'(mem_req_tag), 64'(8'h31 + k));
    end
    in_req_valid = 1'b0;
    chk_vec("b2b_pend", 64'(pending), 64'd1);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk_vec("b2b_pend0", 64'(pending), 64'd0);
    chk_vec("b2b_err",   64'(rsp_err), 64'd0);

    // ---------------- response with nothing outstanding ----------------
    in_rsp_ready  = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = 8'h07;
    settle();
    chk_vec("noack_ready", 64'(mem_rsp_ready), 64'd0);
    tick();
    chk_vec("noack_err", 64'(rsp_err), 64'd0);
    in_rsp_ready = 1'b1;
    settle();
    chk_vec("und_valid", 64'(in_rsp_valid), 64'd1);
    chk_vec("und_tag",   64'(in_rsp_tag),   64'h7);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk_vec("und_pend", 64'(pending), 64'd0);
    chk_vec("und_err",  64'(rsp_err), 64'd1);
    tick();
    chk_vec("und_sticky", 64'(rsp_err), 64'd1);

    // ---------------- reset mid-transfer ----------------
    mem_req_ready = 1'b0;
    drive_req(1'b0, 26'h500, 8'h50);
    tick();
    in_req_valid = 1'b0;
    settle();
    chk_vec("mid_full", 64'(mem_req_valid), 64'd1);
    do_reset();
    settle();
    chk_vec("mid_valid", 64'(mem_req_valid), 64'd0);
    chk_vec("mid_pend",  64'(pending),       64'd0);
    chk_vec("mid_err",   64'(rsp_err),       64'd0);
    chk_vec("mid_ready", 64'(in_req_ready),  64'd1);
`ifdef VX_MEM_FLOW_PERF_EN
    chk_vec("perf_rst_rd", perf_reads,        64'd0);
    chk_vec("perf_rst_wr", perf_writes,       64'd0);
    chk_vec("perf_rst_st", perf_stall_cycles, 64'd0);
`endif
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = 8'h50;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk_vec("late_err",  64'(rsp_err), 64'd1);
    chk_vec("late_pend", 64'(pending), 64'd0);

    // ---------------- 3 reads, 2 writes, 5 stall cycles ----------------
    drive_req(1'b0, 26'h600, 8'h40);
    settle();
    chk_vec("pf_ready0", 64'(in_req_ready), 64'd1);
    tick();
    drive_req(1'b0, 26'h601, 8'h41);
    for (int i = 0; i < 5; i++) tick();
    mem_req_ready = 1'b1;
    settle();
    chk_vec("pf_ready1", 64'(in_req_ready), 64'd1);
    tick();
    drive_req(1'b0, 26'h602, 8'h42);
    tick();
    drive_req(1'b1, 26'h603, 8'h43);
    tick();
    drive_req(1'b1, 26'h604, 8'h44);
    tick();
    in_req_valid = 1'b0;
    settle();
    chk_vec("pf_pend",   64'(pending),    64'd3);
    chk_vec("pf_lasttag", 64'(mem_req_tag), 64'h44);
`ifdef VX_MEM_FLOW_PERF_EN
    chk_vec("perf_reads",  perf_reads,        64'd3);
    chk_vec("perf_writes", perf_writes,       64'd2);
    chk_vec("perf_stall",  perf_stall_cycles, 64'd5);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
